// File: rtl/cpu_defs.sv
// Shared fetch-path definitions: data widths, the canonical NOP encoding and
// the layout of one fetch entry handed to decode.
package cpu_defs;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0, x0, 0 -- placed in the instruction slot of exception entries
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            exc;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Instruction fetches must be 4-byte aligned
  function automatic logic pc_misaligned(input logic [XLEN-1:0] fpc);
    return fpc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a synchronous clear, one push and one pop per cycle.
// Latency: an entry pushed in cycle N is at the head in N+1 (no bypass path).
// Backpressure: push while full is accepted only with a same-cycle pop; clear overrides both.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; clear empties the queue
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // The owner must never push into a full queue without popping
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!push || !full || pop);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: issues imem reads for pc, pairs responses with their pc and queues them for decode.
// Latency: fire in N with a 1-cycle memory -> fetch_o_valid in N+2; misaligned pc entry visible in N+1.
// Backpressure: stops issuing when the output queue plus in-flight reads would exceed FIFO_DEPTH.
module ifu_fetch
  import cpu_defs::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            execute_i_need_jump,
  output logic [XLEN-1:0] fetch_o_pre_pc,
  output logic            fetch_o_pc_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            fetch_o_valid,
  input  logic            decode_i_ready,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic [ILEN-1:0] fetch_o_inst,
  output logic            fetch_o_exc
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1) + 1;

  // inflight: live requests whose pc sits in the pc queue
  // drop: requests issued before a redirect whose data must be thrown away
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             aligned, can_issue, room_mem, room_out;
  logic             req_fire, exc_fire, rsp_take, rsp_drop;

  logic [XLEN-1:0]  pcq_head;
  logic [CNT_W-1:0] pcq_count;
  logic             pcq_full, pcq_empty;

  fetch_entry_t     outq_push_dat, outq_head;
  logic             outq_push, outq_pop;
  logic [OCC_W-1:0] outq_count;
  logic             outq_full, outq_empty;

  // Issue decision and response routing
  always_comb begin
    aligned   = !pc_misaligned(pc);
    room_mem  = (SUM_W'(inflight_q) + SUM_W'(drop_q)) < SUM_W'(MAX_OUTSTANDING);
    room_out  = (SUM_W'(inflight_q) + SUM_W'(outq_count)) < SUM_W'(FIFO_DEPTH);
    can_issue = !rst && !execute_i_need_jump && room_mem && room_out;
    // A misaligned pc must wait until older reads have drained so order is kept
    req_fire  = can_issue && aligned && imem_req_ready;
    exc_fire  = can_issue && !aligned && pcq_empty;
    rsp_drop  = imem_rsp_valid && !execute_i_need_jump && (drop_q != '0);
    rsp_take  = imem_rsp_valid && !execute_i_need_jump && (drop_q == '0);
  end

  assign imem_req_valid = can_issue && aligned;
  assign imem_req_addr  = pc;
  assign fetch_o_pc_en  = req_fire || exc_fire;
  assign fetch_o_pre_pc = pc + XLEN'(4);

  // Output queue push source: a memory response or a synthesised exception entry
  always_comb begin
    outq_push     = rsp_take || exc_fire;
    outq_push_dat = '{pc: pcq_head, inst: imem_rsp_data, exc: 1'b0};
    if (exc_fire) begin
      outq_push_dat = '{pc: pc, inst: INST_NOP, exc: 1'b1};
    end
  end

  // Counter update; a redirect turns everything in flight into drops
  always_comb begin
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (execute_i_need_jump) begin
      drop_d     = drop_q + inflight_q - CNT_W'(imem_rsp_valid);
      inflight_d = '0;
    end else begin
      if (rsp_drop) begin
        drop_d = drop_q - 1'b1;
      end
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk      (clk),
    .rst      (rst),
    .clear    (execute_i_need_jump),
    .push     (req_fire),
    .push_dat (pc),
    .pop      (rsp_take),
    .head_dat (pcq_head),
    .count    (pcq_count),
    .full     (pcq_full),
    .empty    (pcq_empty)
  );

  assign outq_pop = fetch_o_valid && decode_i_ready && !execute_i_need_jump;

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_outq (
    .clk      (clk),
    .rst      (rst),
    .clear    (execute_i_need_jump),
    .push     (outq_push),
    .push_dat (outq_push_dat),
    .pop      (outq_pop),
    .head_dat (outq_head),
    .count    (outq_count),
    .full     (outq_full),
    .empty    (outq_empty)
  );

  assign fetch_o_valid = !rst && !outq_empty;
  assign fetch_o_pc    = rst ? '0 : outq_head.pc;
  assign fetch_o_inst  = rst ? '0 : outq_head.inst;
  assign fetch_o_exc   = rst ? 1'b0 : outq_head.exc;

  // Bookkeeping invariants: no orphan responses, pc queue mirrors inflight, no overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!imem_rsp_valid || inflight_q != '0 || drop_q != '0);
      assert (pcq_count == inflight_q);
      assert (!req_fire || !pcq_full);
      assert (!rsp_take || !outq_full || outq_pop);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch: the bench plays PC register and instruction memory,
// and a scoreboard checks that decode sees, in order, one entry per fetch since the last redirect.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        execute_i_need_jump;
  logic [63:0] fetch_o_pre_pc;
  logic        fetch_o_pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_o_valid;
  logic        decode_i_ready;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_inst;
  logic        fetch_o_exc;

  always #5 clk = ~clk;

  ifu_fetch #(.MAX_OUTSTANDING(2), .FIFO_DEPTH(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc                  (pc),
    .execute_i_need_jump (execute_i_need_jump),
    .fetch_o_pre_pc      (fetch_o_pre_pc),
    .fetch_o_pc_en       (fetch_o_pc_en),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_req_addr       (imem_req_addr),
    .imem_rsp_valid      (imem_rsp_valid),
    .imem_rsp_data       (imem_rsp_data),
    .fetch_o_valid       (fetch_o_valid),
    .decode_i_ready      (decode_i_ready),
    .fetch_o_pc          (fetch_o_pc),
    .fetch_o_inst        (fetch_o_inst),
    .fetch_o_exc         (fetch_o_exc)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mrsp_t;

  exp_t        exp_q[$];
  mrsp_t       mem_q[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rdy_pct = 100;
  int          dec_pct = 100;
  logic [63:0] pc_reg;
  logic [63:0] reset_pc;

  logic        s_pc_en, s_req_vld, s_o_vld, s_o_exc;
  logic [63:0] s_req_addr, s_pre_pc, s_o_pc;
  logic [31:0] s_o_inst;

  // Memory contents: an arbitrary but fixed scramble of the address
  function automatic logic [31:0] memf(input logic [63:0] a);
    logic [31:0] x;
    x = a[31:0] * 32'h9E37_79B1;
    return x ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: drive inputs after the falling edge, sample, then advance the bench models
  task automatic cycle(input logic r, input logic j, input logic [63:0] tgt);
    int due;
    @(negedge clk);
    cyc++;
    rst                 = r;
    execute_i_need_jump = r ? 1'b0 : j;
    pc                  = pc_reg;
    imem_req_ready      = int'($urandom_range(99)) < rdy_pct;
    decode_i_ready      = int'($urandom_range(99)) < dec_pct;
    if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_pc_en    = fetch_o_pc_en;
    s_req_vld  = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_pre_pc   = fetch_o_pre_pc;
    s_o_vld    = fetch_o_valid;
    s_o_pc     = fetch_o_pc;
    s_o_inst   = fetch_o_inst;
    s_o_exc    = fetch_o_exc;
    if (r) begin
      chk("rst_req_vld", 64'(s_req_vld), 64'd0);
      chk("rst_pc_en",   64'(s_pc_en),   64'd0);
      chk("rst_o_vld",   64'(s_o_vld),   64'd0);
      chk("rst_o_pc",    s_o_pc,         64'd0);
      chk("rst_o_inst",  64'(s_o_inst),  64'd0);
      chk("rst_o_exc",   64'(s_o_exc),   64'd0);
      exp_q.delete();
      mem_q.delete();
      last_due = 0;
      pc_reg   = reset_pc;
    end else begin
      chk("pre_pc", s_pre_pc, pc + 64'd4);
      if (execute_i_need_jump) begin
        chk("flush_no_fire", 64'(s_pc_en),   64'd0);
        chk("flush_no_req",  64'(s_req_vld), 64'd0);
      end else if (pc[1:0] == 2'b00) begin
        chk("pc_en_vs_handshake", 64'(s_pc_en), 64'(s_req_vld && imem_req_ready));
      end else begin
        chk("misaligned_no_req", 64'(s_req_vld), 64'd0);
      end
      if (s_req_vld) chk("req_addr", s_req_addr, pc);
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (s_req_vld && imem_req_ready) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        mem_q.push_back('{data: memf(pc), due: due});
        last_due = due;
        chk("outstanding_bound", 64'(mem_q.size() <= 2), 64'd1);
      end
      if (execute_i_need_jump) begin
        exp_q.delete();
        pc_reg = tgt;
      end else if (s_pc_en) begin
        if (pc[1:0] == 2'b00) exp_q.push_back('{pc: pc, inst: memf(pc), exc: 1'b0});
        else                  exp_q.push_back('{pc: pc, inst: NOP,      exc: 1'b1});
        pc_reg = pc + 64'd4;
      end
    end
  endtask

  // Run normal cycles until decode sees a valid entry, within a cycle budget
  task automatic wait_valid(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      cycle(1'b0, 1'b0, 64'd0);
      if (s_o_vld) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s: fetch_o_valid never rose within %0d cycles, required 1", name, budget);
  endtask

  // Scoreboard monitor: every entry decode accepts must match the oldest expected fetch
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst === 1'b0 && execute_i_need_jump === 1'b0 &&
          fetch_o_valid === 1'b1 && decode_i_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: entry pc=0x%0h accepted, required none pending", fetch_o_pc);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          chk("sb_pc",   fetch_o_pc,         e.pc);
          chk("sb_inst", 64'(fetch_o_inst),  64'(e.inst));
          chk("sb_exc",  64'(fetch_o_exc),   64'(e.exc));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int p0;
    logic        rr, jj;
    logic [63:0] tgt;
    rst = 1'b1; execute_i_need_jump = 1'b0; pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; decode_i_ready = 1'b0;

    // Reset, then first fetch and its two-cycle latency
    reset_pc = 64'h8000_0000; pc_reg = reset_pc;
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    repeat (3) cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t1_first_fire", 64'(s_pc_en), 64'd1);
    chk("t1_addr",       s_req_addr,   64'h8000_0000);
    chk("t1_pre_pc",     s_pre_pc,     64'h8000_0004);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t1_not_yet_valid", 64'(s_o_vld), 64'd0);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t1_valid_n2", 64'(s_o_vld),  64'd1);
    chk("t1_head_pc",  s_o_pc,        64'h8000_0000);
    chk("t1_head_inst", 64'(s_o_inst), 64'(memf(64'h8000_0000)));
    repeat (20) cycle(1'b0, 1'b0, 64'd0);

    // Decode stall: exactly two fetches held, then drained without loss
    dec_pct = 0;
    repeat (12) cycle(1'b0, 1'b0, 64'd0);
    chk("t2_req_vld_low", 64'(s_req_vld),    64'd0);
    chk("t2_o_vld_held",  64'(s_o_vld),      64'd1);
    chk("t2_queued",      64'(exp_q.size()), 64'd2);
    dec_pct = 100;
    p0 = n_pop;
    repeat (10) cycle(1'b0, 1'b0, 64'd0);
    chk("t2_drained", 64'(n_pop - p0 >= 2), 64'd1);

    // Redirect with two slow reads in flight
    lat_min = 3; lat_max = 3;
    repeat (2) cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t3_fire0", 64'(s_pc_en), 64'd1);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t3_fire1", 64'(s_pc_en), 64'd1);
    chk("t3_two_outstanding", 64'(mem_q.size()), 64'd2);
    cycle(1'b0, 1'b1, 64'h8000_1000);
    wait_valid("t3_wait", 20);
    chk("t3_first_pc",   s_o_pc,        64'h8000_1000);
    chk("t3_first_inst", 64'(s_o_inst), 64'(memf(64'h8000_1000)));
    repeat (10) cycle(1'b0, 1'b0, 64'd0);

    // Misaligned pc: no memory read, exception entry carrying a NOP
    lat_min = 1; lat_max = 1;
    reset_pc = 64'h8000_0002;
    repeat (2) cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t4_no_req", 64'(s_req_vld), 64'd0);
    chk("t4_pc_en",  64'(s_pc_en),   64'd1);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t4_valid", 64'(s_o_vld),  64'd1);
    chk("t4_pc",    s_o_pc,        64'h8000_0002);
    chk("t4_inst",  64'(s_o_inst), 64'h13);
    chk("t4_exc",   64'(s_o_exc),  64'd1);
    repeat (8) cycle(1'b0, 1'b0, 64'd0);

    // Memory accept toggling: pc only advances on accepted requests
    reset_pc = 64'h8000_0000;
    repeat (2) cycle(1'b1, 1'b0, 64'd0);
    for (int k = 0; k < 6; k++) begin
      rdy_pct = (k % 2 == 0) ? 100 : 0;
      cycle(1'b0, 1'b0, 64'd0);
      if (k % 2 == 0) begin
        chk("t5_fire_accepted", 64'(s_pc_en), 64'd1);
        chk("t5_addr", s_req_addr, 64'h8000_0000 + 64'(4 * (k / 2)));
      end else begin
        chk("t5_req_pending", 64'(s_req_vld), 64'd1);
        chk("t5_no_fire",     64'(s_pc_en),   64'd0);
      end
    end
    rdy_pct = 100;
    repeat (6) cycle(1'b0, 1'b0, 64'd0);

    // Reset in the middle of a stalled stream
    dec_pct = 0;
    repeat (10) cycle(1'b0, 1'b0, 64'd0);
    chk("t6_full_before", 64'(s_o_vld), 64'd1);
    reset_pc = 64'h8000_0100;
    dec_pct = 100;
    cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 64'd0);
    chk("t6_cleared",  64'(s_o_vld), 64'd0);
    chk("t6_restart",  64'(s_pc_en), 64'd1);
    chk("t6_addr",     s_req_addr,   64'h8000_0100);
    wait_valid("t6_wait", 10);
    chk("t6_first_pc", s_o_pc, 64'h8000_0100);

    // Randomised traffic: latencies, stalls, redirects, misaligned targets, resets
    for (int blk = 0; blk < 40; blk++) begin
      lat_min = int'($urandom_range(1, 3));
      lat_max = lat_min + int'($urandom_range(2));
      rdy_pct = int'($urandom_range(30, 100));
      dec_pct = int'($urandom_range(20, 100));
      for (int k = 0; k < 60; k++) begin
        rr  = ($urandom_range(199) == 0);
        jj  = ($urandom_range(99) < 6);
        tgt = 64'h8000_0000 + 64'($urandom_range(16383)) * 64'd4;
        if ($urandom_range(9) == 0) tgt = tgt + 64'($urandom_range(1, 3));
        if (rr) reset_pc = 64'h8000_0000 + 64'($urandom_range(4095)) * 64'd4;
        cycle(rr, jj, tgt);
      end
    end
    chk("sb_activity", 64'(n_pop > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
